// File: rtl/input_port.sv
`default_nettype none
// ============================================================================
//  Module   : input_port
//  Purpose  : Router input stage. Buffers incoming flits in per-VC FIFOs,
//             computes the XY output port of each head flit, runs a per-VC
//             IDLE/VA/ACTIVE state machine that requests a downstream VC and
//             then switch access, and forwards granted flits with the VC id
//             rewritten to the allocated downstream VC.
//  Options  : INPUT_PORT_OVERFLOW_FLAG_EN adds the sticky overflow_o flag
//             that records any push dropped at a full FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module input_port #(
    parameter int VC_NUM         = 2,
    parameter int VC_SIZE        = 1,
    parameter int BUFFER_SIZE    = 8,
    parameter int DEST_ADDR_SIZE = 2,
    parameter int FLIT_SIZE      = 32,
    parameter int ROUTER_X       = 0,
    parameter int ROUTER_Y       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_flit_i,
    input  logic [FLIT_SIZE-1:0]              flit_i,
    output logic [VC_NUM-1:0]                 credit_o,
    output logic [VC_NUM-1:0]                 vc_request_o,
    output logic [VC_NUM-1:0][2:0]            out_port_o,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]    vc_new_i,
    input  logic [VC_NUM-1:0]                 vc_valid_i,
    output logic [VC_NUM-1:0]                 sa_request_o,
    input  logic [VC_NUM-1:0]                 sa_grant_i,
    output logic [FLIT_SIZE-1:0]              flit_o,
    output logic                              flit_valid_o
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
    ,
    output logic                              overflow_o
`endif
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    localparam int c_PTR_W  = $clog2(BUFFER_SIZE) + 1;
    localparam int c_ADDR_W = c_PTR_W - 1;
    localparam int c_DX_LO  = VC_SIZE + 2;
    localparam int c_DY_LO  = c_DX_LO + DEST_ADDR_SIZE;

    localparam logic [DEST_ADDR_SIZE-1:0] c_ROUTER_X = DEST_ADDR_SIZE'(ROUTER_X);
    localparam logic [DEST_ADDR_SIZE-1:0] c_ROUTER_Y = DEST_ADDR_SIZE'(ROUTER_Y);

    localparam logic [1:0] c_HEAD     = 2'b00;
    localparam logic [1:0] c_TAIL     = 2'b10;
    localparam logic [1:0] c_HEADTAIL = 2'b11;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_VA     = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;

    localparam logic [2:0] c_LOCAL = 3'd0;
    localparam logic [2:0] c_NORTH = 3'd1;
    localparam logic [2:0] c_SOUTH = 3'd2;
    localparam logic [2:0] c_EAST  = 3'd3;
    localparam logic [2:0] c_WEST  = 3'd4;

    logic [FLIT_SIZE-1:0] r_mem    [VC_NUM][BUFFER_SIZE];
    logic [c_PTR_W-1:0]   r_wr_ptr [VC_NUM];
    logic [c_PTR_W-1:0]   r_rd_ptr [VC_NUM];
    logic [1:0]           r_state  [VC_NUM];
    logic [VC_SIZE-1:0]   r_vc_new [VC_NUM];

    logic [FLIT_SIZE-1:0] w_front  [VC_NUM];
    logic [2:0]           w_route  [VC_NUM];
    logic [VC_NUM-1:0]    w_empty;
    logic [VC_NUM-1:0]    w_full;
    logic [VC_NUM-1:0]    w_push;
    logic [VC_NUM-1:0]    w_accept;
    logic [VC_NUM-1:0]    w_pop;
    logic [VC_NUM-1:0]    w_head_front;
    logic [VC_NUM-1:0]    w_last_front;
    logic                 w_grant_ok;

    // X is resolved before Y; equal coordinates deliver locally
    function automatic logic [2:0] xy_route(input logic [DEST_ADDR_SIZE-1:0] dx,
                                            input logic [DEST_ADDR_SIZE-1:0] dy);
        if (dx > c_ROUTER_X)      return c_EAST;
        else if (dx < c_ROUTER_X) return c_WEST;
        else if (dy > c_ROUTER_Y) return c_SOUTH;
        else if (dy < c_ROUTER_Y) return c_NORTH;
        else                      return c_LOCAL;
    endfunction

    // FIFO status, front-flit decode and per-VC request generation
    always_comb begin
        w_front      = '{default: '0};
        w_route      = '{default: '0};
        w_empty      = '0;
        w_full       = '0;
        w_push       = '0;
        w_head_front = '0;
        w_last_front = '0;
        vc_request_o = '0;
        sa_request_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_front[v]      = r_mem[v][r_rd_ptr[v][c_ADDR_W-1:0]];
            w_route[v]      = xy_route(w_front[v][c_DX_LO +: DEST_ADDR_SIZE],
                                       w_front[v][c_DY_LO +: DEST_ADDR_SIZE]);
            w_empty[v]      = (r_wr_ptr[v] == r_rd_ptr[v]);
            w_full[v]       = (r_wr_ptr[v][c_PTR_W-1] != r_rd_ptr[v][c_PTR_W-1]) &&
                              (r_wr_ptr[v][c_ADDR_W-1:0] == r_rd_ptr[v][c_ADDR_W-1:0]);
            w_push[v]       = valid_flit_i && (flit_i[VC_SIZE+1:2] == VC_SIZE'(v));
            w_head_front[v] = (w_front[v][1:0] == c_HEAD) || (w_front[v][1:0] == c_HEADTAIL);
            w_last_front[v] = (w_front[v][1:0] == c_TAIL) || (w_front[v][1:0] == c_HEADTAIL);
            vc_request_o[v] = (r_state[v] == c_VA);
            sa_request_o[v] = (r_state[v] == c_ACTIVE) && !w_empty[v];
        end
    end

    // Grant qualification, pop/push acceptance and the forwarded flit
    always_comb begin
        w_grant_ok   = $onehot(sa_grant_i);
        w_pop        = sa_grant_i & sa_request_o & {VC_NUM{w_grant_ok}};
        // A pop in the same cycle frees the slot a full FIFO needs
        w_accept     = w_push & (~w_full | w_pop);
        credit_o     = w_pop;
        flit_valid_o = |w_pop;
        flit_o       = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_pop[v]) begin
                flit_o              = w_front[v];
                flit_o[VC_SIZE+1:2] = r_vc_new[v];
            end
        end
    end

    // Flit storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_accept[v]) begin
                r_mem[v][r_wr_ptr[v][c_ADDR_W-1:0]] <= flit_i;
            end
        end
    end

    // Per-VC pointers and IDLE/VA/ACTIVE state machine with latched route/VC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wr_ptr[v]   <= '0;
                r_rd_ptr[v]   <= '0;
                r_state[v]    <= c_IDLE;
                r_vc_new[v]   <= '0;
                out_port_o[v] <= c_LOCAL;
            end
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_accept[v]) r_wr_ptr[v] <= r_wr_ptr[v] + c_PTR_W'(1);
                if (w_pop[v])    r_rd_ptr[v] <= r_rd_ptr[v] + c_PTR_W'(1);
                case (r_state[v])
                    c_IDLE: begin
                        // A BODY/TAIL at the front never starts a packet and stalls the VC
                        if (!w_empty[v] && w_head_front[v]) begin
                            out_port_o[v] <= w_route[v];
                            r_state[v]    <= c_VA;
                        end
                    end
                    c_VA: begin
                        if (vc_valid_i[v]) begin
                            r_vc_new[v] <= vc_new_i[v];
                            r_state[v]  <= c_ACTIVE;
                        end
                    end
                    c_ACTIVE: begin
                        if (w_pop[v] && w_last_front[v]) r_state[v] <= c_IDLE;
                    end
                    default: r_state[v] <= c_IDLE;
                endcase
            end
        end
    end

`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
    // Sticky record of any push lost to a full FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (|(w_push & ~w_accept)) begin
            overflow_o <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_port
//  Purpose  : Self-checking bench for input_port (router at X=1, Y=1).
//             Directed scenarios plus a randomized run against a queue-based
//             reference model of the port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_port;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_SOUTH = 3'd2;
    localparam logic [2:0] P_EAST  = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;
    localparam logic [1:0] T_HEAD  = 2'b00;
    localparam logic [1:0] T_BODY  = 2'b01;
    localparam logic [1:0] T_TAIL  = 2'b10;
    localparam logic [1:0] T_HT    = 2'b11;

    logic             clk;
    logic             rst;
    logic             valid_flit_i;
    logic [31:0]      flit_i;
    logic [1:0]       credit_o;
    logic [1:0]       vc_request_o;
    logic [1:0][2:0]  out_port_o;
    logic [1:0][0:0]  vc_new_i;
    logic [1:0]       vc_valid_i;
    logic [1:0]       sa_request_o;
    logic [1:0]       sa_grant_i;
    logic [31:0]      flit_o;
    logic             flit_valid_o;
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
    logic             overflow_o;
`endif

    int errors = 0;
    int checks = 0;

    input_port #(
        .VC_NUM(2), .VC_SIZE(1), .BUFFER_SIZE(8), .DEST_ADDR_SIZE(2),
        .FLIT_SIZE(32), .ROUTER_X(1), .ROUTER_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .valid_flit_i(valid_flit_i), .flit_i(flit_i),
        .credit_o(credit_o), .vc_request_o(vc_request_o), .out_port_o(out_port_o),
        .vc_new_i(vc_new_i), .vc_valid_i(vc_valid_i), .sa_request_o(sa_request_o),
        .sa_grant_i(sa_grant_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o)
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
        , .overflow_o(overflow_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] mq [0:1][$];
    int          mst [2];      // 0 idle, 1 waiting for VC, 2 sending packet
    logic [2:0]  mport [2];
    logic        mvcn [2];
    bit          movf;
    int          rem [2];
    logic [1:0]  e_vcreq, e_sareq, e_pop;
    logic [31:0] e_flit;
    logic        e_fv;

    function automatic logic [31:0] mkflit(input logic [1:0] t, input logic vc,
                                           input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [24:0] pl);
        return {pl, dy, dx, vc, t};
    endfunction

    function automatic logic [31:0] repl(input logic [31:0] f, input logic vc);
        logic [31:0] r;
        r = f;
        r[2] = vc;
        return r;
    endfunction

    function automatic logic [2:0] ref_route(input int dx, input int dy);
        if (dx > 1) return P_EAST;
        if (dx < 1) return P_WEST;
        if (dy > 1) return P_SOUTH;
        if (dy < 1) return P_NORTH;
        return P_LOCAL;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            mq[v].delete();
            mst[v] = 0; mport[v] = P_LOCAL; mvcn[v] = 1'b0; rem[v] = 0;
        end
        movf = 1'b0;
    endtask

    task automatic model_eval();
        logic onehot;
        onehot = (sa_grant_i == 2'b01) || (sa_grant_i == 2'b10);
        e_flit = '0;
        for (int v = 0; v < 2; v++) begin
            e_vcreq[v] = (mst[v] == 1);
            e_sareq[v] = (mst[v] == 2) && (mq[v].size() > 0);
            e_pop[v]   = onehot && sa_grant_i[v] && e_sareq[v];
            if (e_pop[v]) e_flit = repl(mq[v][0], mvcn[v]);
        end
        e_fv = |e_pop;
    endtask

    task automatic model_commit();
        logic [31:0] f;
        int          vc;
        for (int v = 0; v < 2; v++) begin
            if (e_pop[v]) begin
                f = mq[v].pop_front();
                if (f[1:0] == T_TAIL || f[1:0] == T_HT) mst[v] = 0;
            end else if (mst[v] == 0 && mq[v].size() > 0 &&
                         (mq[v][0][1:0] == T_HEAD || mq[v][0][1:0] == T_HT)) begin
                mport[v] = ref_route(int'(mq[v][0][4:3]), int'(mq[v][0][6:5]));
                mst[v] = 1;
            end else if (mst[v] == 1 && vc_valid_i[v]) begin
                mvcn[v] = vc_new_i[v][0];
                mst[v] = 2;
            end
        end
        if (valid_flit_i) begin
            vc = int'(flit_i[2]);
            if (mq[vc].size() < 8) mq[vc].push_back(flit_i);
            else movf = 1'b1;
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        valid_flit_i = 1'b0; flit_i = '0; vc_valid_i = '0; vc_new_i = '0; sa_grant_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        #2;
        checks++; if (vc_request_o !== 2'b00) begin errors++; $display("FAIL reset_vcreq: got %b expected 00", vc_request_o); end
        checks++; if (sa_request_o !== 2'b00) begin errors++; $display("FAIL reset_sareq: got %b expected 00", sa_request_o); end
        checks++; if (credit_o !== 2'b00) begin errors++; $display("FAIL reset_credit: got %b expected 00", credit_o); end
        checks++; if (flit_valid_o !== 1'b0 || flit_o !== 32'h0) begin errors++; $display("FAIL reset_flit: got v=%b %h expected v=0 0", flit_valid_o, flit_o); end
        checks++; if (out_port_o !== 6'h0) begin errors++; $display("FAIL reset_port: got %h expected 0", out_port_o); end
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_east();
        logic [31:0] f;
        do_reset();
        f = mkflit(T_HT, 1'b0, 2'd3, 2'd1, 25'h1abcde);
        valid_flit_i = 1'b1; flit_i = f;
        step();
        valid_flit_i = 1'b0;
        #1;
        checks++; if (vc_request_o !== 2'b00) begin errors++; $display("FAIL east_vcreq_early: got %b expected 00", vc_request_o); end
        step();
        checks++; if (vc_request_o !== 2'b01) begin errors++; $display("FAIL east_vcreq: got %b expected 01", vc_request_o); end
        checks++; if (out_port_o[0] !== P_EAST) begin errors++; $display("FAIL east_port: got %0d expected %0d", out_port_o[0], P_EAST); end
        vc_valid_i = 2'b01; vc_new_i[0] = 1'b1;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b01 || vc_request_o !== 2'b00) begin errors++; $display("FAIL east_active: got sa=%b vc=%b expected sa=01 vc=00", sa_request_o, vc_request_o); end
        sa_grant_i = 2'b01;
        #1;
        checks++; if (flit_valid_o !== 1'b1 || credit_o !== 2'b01) begin errors++; $display("FAIL east_pop: got v=%b credit=%b expected v=1 credit=01", flit_valid_o, credit_o); end
        checks++; if (flit_o !== repl(f, 1'b1)) begin errors++; $display("FAIL east_flit: got %h expected %h", flit_o, repl(f, 1'b1)); end
        step();
        sa_grant_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b00 || credit_o !== 2'b00) begin errors++; $display("FAIL east_after: got sa=%b credit=%b expected 00 00", sa_request_o, credit_o); end
        valid_flit_i = 1'b1; flit_i = mkflit(T_HT, 1'b0, 2'd1, 2'd1, 25'h5);
        step();
        valid_flit_i = 1'b0;
        step();
        checks++; if (vc_request_o !== 2'b01) begin errors++; $display("FAIL east_back_idle: got %b expected 01", vc_request_o); end
    endtask

    task automatic test_routes();
        int dx [10];
        int dy [10];
        logic vc;
        dx[0] = 0; dy[0] = 1; dx[1] = 1; dy[1] = 0; dx[2] = 1; dy[2] = 3; dx[3] = 1; dy[3] = 1;
        for (int i = 4; i < 10; i++) begin dx[i] = int'($urandom_range(0, 3)); dy[i] = int'($urandom_range(0, 3)); end
        for (int i = 0; i < 10; i++) begin
            logic [2:0] exp_p;
            if (i == 0) exp_p = P_WEST;
            else if (i == 1) exp_p = P_NORTH;
            else if (i == 2) exp_p = P_SOUTH;
            else if (i == 3) exp_p = P_LOCAL;
            else exp_p = ref_route(dx[i], dy[i]);
            do_reset();
            vc = 1'($urandom_range(0, 1));
            valid_flit_i = 1'b1;
            flit_i = mkflit(T_HT, vc, 2'(dx[i]), 2'(dy[i]), 25'($urandom));
            step();
            valid_flit_i = 1'b0;
            step();
            checks++; if (out_port_o[vc] !== exp_p) begin errors++; $display("FAIL route_%0d: got %0d expected %0d (dest %0d,%0d)", i, out_port_o[vc], exp_p, dx[i], dy[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] fl [10];
        do_reset();
        for (int i = 0; i < 10; i++)
            fl[i] = mkflit(i == 0 ? T_HEAD : (i == 9 ? T_TAIL : T_BODY), 1'b1, 2'd0, 2'd1, 25'(i + 16));
        for (int i = 0; i < 9; i++) begin
            valid_flit_i = 1'b1; flit_i = fl[i];
            step();
        end
        valid_flit_i = 1'b0;
        #1;
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_o); end
`endif
        vc_valid_i = 2'b10; vc_new_i[1] = 1'b0;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b10) begin errors++; $display("FAIL ovf_sareq: got %b expected 10", sa_request_o); end
        valid_flit_i = 1'b1; flit_i = fl[9]; sa_grant_i = 2'b10;
        #1;
        checks++; if (credit_o !== 2'b10 || flit_o !== repl(fl[0], 1'b0)) begin errors++; $display("FAIL ovf_pushpop: got credit=%b %h expected 10 %h", credit_o, flit_o, repl(fl[0], 1'b0)); end
        step();
        valid_flit_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ef;
            ef = (k < 7) ? repl(fl[k + 1], 1'b0) : repl(fl[9], 1'b0);
            sa_grant_i = 2'b10;
            #1;
            checks++; if (flit_valid_o !== 1'b1 || flit_o !== ef) begin errors++; $display("FAIL ovf_drain_%0d: got v=%b %h expected v=1 %h", k, flit_valid_o, flit_o, ef); end
            step();
        end
        sa_grant_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b00) begin errors++; $display("FAIL ovf_empty: got %b expected 00", sa_request_o); end
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", overflow_o); end
        do_reset();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow_o); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [$];
        logic [31:0] b [$];
        logic [31:0] wr [5];
        do_reset();
        a.push_back(mkflit(T_HEAD, 1'b0, 2'd3, 2'd1, 25'h100));
        a.push_back(mkflit(T_BODY, 1'b0, 2'd0, 2'd0, 25'h101));
        a.push_back(mkflit(T_BODY, 1'b0, 2'd0, 2'd0, 25'h102));
        a.push_back(mkflit(T_TAIL, 1'b0, 2'd0, 2'd0, 25'h103));
        b.push_back(mkflit(T_HT, 1'b1, 2'd1, 2'd0, 25'h200));
        wr[0] = a[0]; wr[1] = b[0]; wr[2] = a[1]; wr[3] = a[2]; wr[4] = a[3];
        for (int i = 0; i < 5; i++) begin
            valid_flit_i = 1'b1; flit_i = wr[i];
            step();
        end
        valid_flit_i = 1'b0;
        vc_valid_i = 2'b11; vc_new_i[0] = 1'b1; vc_new_i[1] = 1'b0;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (out_port_o !== {P_NORTH, P_EAST}) begin errors++; $display("FAIL b2b_ports: got %h expected %h", out_port_o, {P_NORTH, P_EAST}); end
        for (int c = 0; c < 6; c++) begin
            logic [31:0] ef;
            int sel;
            sel = c % 2;
            if (sel == 1 && b.size() == 0) sel = 0;
            if (sel == 0 && a.size() == 0) sel = 1;
            if (a.size() == 0 && b.size() == 0) break;
            sa_grant_i = (sel == 0) ? 2'b01 : 2'b10;
            ef = (sel == 0) ? repl(a.pop_front(), 1'b1) : repl(b.pop_front(), 1'b0);
            #1;
            checks++; if (vc_request_o !== 2'b00) begin errors++; $display("FAIL b2b_vcreq_%0d: got %b expected 00", c, vc_request_o); end
            checks++; if (flit_valid_o !== 1'b1 || flit_o !== ef) begin errors++; $display("FAIL b2b_flit_%0d: got v=%b %h expected v=1 %h", c, flit_valid_o, flit_o, ef); end
            step();
            sa_grant_i = 2'b00;
            #1;
            if (a.size() > 0) begin
                checks++; if (sa_request_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_vc0_active_%0d: got %b expected 1", c, sa_request_o[0]); end
            end
        end
        checks++; if (sa_request_o !== 2'b00 || vc_request_o !== 2'b00) begin errors++; $display("FAIL b2b_end: got sa=%b vc=%b expected 00 00", sa_request_o, vc_request_o); end
    endtask

    task automatic test_ignored();
        logic [31:0] f;
        do_reset();
        f = mkflit(T_HT, 1'b0, 2'd1, 2'd1, 25'h3c3c);
        valid_flit_i = 1'b1; flit_i = f; vc_valid_i = 2'b01; vc_new_i[0] = 1'b0;
        step();
        valid_flit_i = 1'b0;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (vc_request_o !== 2'b01 || sa_request_o !== 2'b00) begin errors++; $display("FAIL ign_idle: got vc=%b sa=%b expected 01 00", vc_request_o, sa_request_o); end
        vc_valid_i = 2'b01; vc_new_i[0] = 1'b1;
        step();
        vc_new_i[0] = 1'b0;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b01 || vc_request_o !== 2'b00) begin errors++; $display("FAIL ign_active: got sa=%b vc=%b expected 01 00", sa_request_o, vc_request_o); end
        valid_flit_i = 1'b1; flit_i = mkflit(T_HT, 1'b1, 2'd2, 2'd1, 25'h77);
        step();
        valid_flit_i = 1'b0;
        step();
        vc_valid_i = 2'b10; vc_new_i[1] = 1'b1;
        step();
        vc_valid_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b11) begin errors++; $display("FAIL ign_both_req: got %b expected 11", sa_request_o); end
        sa_grant_i = 2'b11;
        #1;
        checks++; if (flit_valid_o !== 1'b0 || credit_o !== 2'b00) begin errors++; $display("FAIL ign_grant11: got v=%b credit=%b expected 0 00", flit_valid_o, credit_o); end
        step();
        sa_grant_i = 2'b00;
        #1;
        checks++; if (sa_request_o !== 2'b11) begin errors++; $display("FAIL ign_nopop: got %b expected 11", sa_request_o); end
        sa_grant_i = 2'b01;
        #1;
        checks++; if (flit_o !== repl(f, 1'b1) || flit_valid_o !== 1'b1) begin errors++; $display("FAIL ign_vcnew_kept: got %h expected %h", flit_o, repl(f, 1'b1)); end
        step();
        sa_grant_i = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [31:0] f;
        do_reset();
        valid_flit_i = 1'b1; flit_i = mkflit(T_HEAD, 1'b0, 2'd2, 2'd2, 25'h11); step();
        flit_i = mkflit(T_BODY, 1'b0, 2'd0, 2'd0, 25'h12); step();
        flit_i = mkflit(T_BODY, 1'b0, 2'd0, 2'd0, 25'h13); step();
        valid_flit_i = 1'b0;
        #1;
        checks++; if (vc_request_o !== 2'b01) begin errors++; $display("FAIL rmid_va: got %b expected 01", vc_request_o); end
        rst = 1'b1;
        model_clear();
        #1;
        checks++; if (vc_request_o !== 2'b00 || sa_request_o !== 2'b00 || credit_o !== 2'b00) begin errors++; $display("FAIL rmid_req: got vc=%b sa=%b credit=%b expected 00", vc_request_o, sa_request_o, credit_o); end
        checks++; if (out_port_o !== 6'h0 || flit_valid_o !== 1'b0 || flit_o !== 32'h0) begin errors++; $display("FAIL rmid_out: got port=%h v=%b %h expected 0", out_port_o, flit_valid_o, flit_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        f = mkflit(T_HT, 1'b0, 2'd0, 2'd1, 25'h99);
        valid_flit_i = 1'b1; flit_i = f;
        step();
        valid_flit_i = 1'b0;
        step();
        checks++; if (vc_request_o !== 2'b01 || out_port_o[0] !== P_WEST) begin errors++; $display("FAIL rmid_new: got vc=%b port=%0d expected 01 %0d", vc_request_o, out_port_o[0], P_WEST); end
        vc_valid_i = 2'b01; vc_new_i[0] = 1'b0;
        step();
        vc_valid_i = 2'b00; sa_grant_i = 2'b01;
        #1;
        checks++; if (flit_valid_o !== 1'b1 || flit_o !== repl(f, 1'b0)) begin errors++; $display("FAIL rmid_flit: got v=%b %h expected v=1 %h", flit_valid_o, flit_o, repl(f, 1'b0)); end
        step();
        sa_grant_i = 2'b00;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int         vc;
            logic [1:0] t;
            idle_inputs();
            vc = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && mq[vc].size() < 8) begin
                if (rem[vc] == 0) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    t = (len == 1) ? T_HT : T_HEAD;
                    rem[vc] = len - 1;
                end else begin
                    rem[vc] = rem[vc] - 1;
                    t = (rem[vc] == 0) ? T_TAIL : T_BODY;
                end
                valid_flit_i = 1'b1;
                flit_i = mkflit(t, 1'(vc), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 25'($urandom));
            end
            vc_valid_i = 2'($urandom_range(0, 3));
            vc_new_i   = 2'($urandom_range(0, 3));
            sa_grant_i = 2'($urandom_range(0, 3));
            model_eval();
            #1;
            checks++; if (vc_request_o !== e_vcreq) begin errors++; $display("FAIL rnd_vcreq c%0d: got %b expected %b", c, vc_request_o, e_vcreq); end
            checks++; if (sa_request_o !== e_sareq) begin errors++; $display("FAIL rnd_sareq c%0d: got %b expected %b", c, sa_request_o, e_sareq); end
            checks++; if (credit_o !== e_pop) begin errors++; $display("FAIL rnd_credit c%0d: got %b expected %b", c, credit_o, e_pop); end
            checks++; if (flit_valid_o !== e_fv || flit_o !== e_flit) begin errors++; $display("FAIL rnd_flit c%0d: got v=%b %h expected v=%b %h", c, flit_valid_o, flit_o, e_fv, e_flit); end
            checks++; if (out_port_o !== {mport[1], mport[0]}) begin errors++; $display("FAIL rnd_port c%0d: got %h expected %h", c, out_port_o, {mport[1], mport[0]}); end
            step();
        end
        idle_inputs();
`ifdef INPUT_PORT_OVERFLOW_FLAG_EN
        #1;
        checks++; if (overflow_o !== movf) begin errors++; $display("FAIL rnd_ovf: got %b expected %b", overflow_o, movf); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        test_reset();
        test_east();
        test_routes();
        test_overflow();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_port.md
Name: input_port

Overview:
- Router input stage, directly upstream of vc_allocator and switch allocator.
- Buffers incoming flits in per-VC FIFOs and computes the XY output port for each head flit.
- Runs a per-VC state machine (IDLE/VA/ACTIVE) that issues VC requests to vc_allocator and switch requests to the switch allocator.
- Forwards granted flits with the VC id rewritten to the allocated downstream VC.

Parameters:
- VC_NUM, 2, virtual channels per port.
- VC_SIZE, 1, VC id width; equals $clog2(VC_NUM).
- BUFFER_SIZE, 8, flits per VC FIFO; power of two, at least 2.
- DEST_ADDR_SIZE, 2, width of each destination coordinate field.
- FLIT_SIZE, 32, total flit width.
- ROUTER_X, 0, this router's X coordinate.
- ROUTER_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_flit_i  in  1  flit_i is valid this cycle.
- flit_i  in  FLIT_SIZE  flit. Field layout:
  - [1:0] type: HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.
  - [VC_SIZE+1:2] vc id.
  - next DEST_ADDR_SIZE bits: dest_x.
  - next DEST_ADDR_SIZE bits: dest_y.
  - remaining bits: payload.
- credit_o  out  VC_NUM  one-cycle pulse per VC when a flit is popped.
- vc_request_o  out  VC_NUM  VC allocation request per VC.
- out_port_o  out  VC_NUM x port_t  registered output port per VC.
- vc_new_i  in  VC_NUM x VC_SIZE  allocated downstream VC.
- vc_valid_i  in  VC_NUM  vc_new_i valid for that VC.
- sa_request_o  out  VC_NUM  switch allocation request per VC.
- sa_grant_i  in  VC_NUM  one-hot switch grant.
- flit_o  out  FLIT_SIZE  forwarded flit, vc field = allocated VC.
- flit_valid_o  out  1  flit_o valid.
- overflow_o  out  1  sticky overflow flag; present only with INPUT_PORT_OVERFLOW_FLAG_EN.

Behaviour:
- Reset values: all FIFOs empty, pointers 0, every VC in IDLE, out_port_o all LOCAL, vc_new registers 0. All outputs 0: credit_o, vc_request_o, sa_request_o, flit_o, flit_valid_o, overflow_o.
- Write: when valid_flit_i=1, flit_i is pushed into the FIFO selected by its vc field at the rising edge.
  - Push to a full FIFO is dropped, unless that same VC pops in the same cycle; then both the push and the pop occur.
  - Pointers wrap modulo BUFFER_SIZE. Full/empty are tracked with an extra pointer bit.
- Route computation is XY, on the front flit:
  - dest_x > ROUTER_X -> EAST; dest_x < ROUTER_X -> WEST.
  - Otherwise dest_y > ROUTER_Y -> SOUTH; dest_y < ROUTER_Y -> NORTH.
  - Otherwise LOCAL.
- Per-VC FSM:
  - IDLE: if the FIFO is non-empty and the front type is HEAD or HEADTAIL, latch the route into out_port_o and move to VA. If the front is BODY or TAIL, stay in IDLE and raise no request; that flit blocks the VC (protocol violation, not recovered).
  - VA: vc_request_o[v]=1. When vc_valid_i[v]=1, latch vc_new_i[v] and move to ACTIVE. vc_valid_i is ignored in other states.
  - ACTIVE: sa_request_o[v] = FIFO non-empty.
    - When sa_grant_i[v]=1 and sa_request_o[v]=1: pop, flit_o = front flit with the vc field replaced by the latched vc_new, flit_valid_o=1 and credit_o[v]=1 in the same cycle (combinational).
    - If the popped flit is TAIL or HEADTAIL, return to IDLE at the next edge.
- Latency: head flit written at edge t -> VA at edge t+1 -> vc_request_o high during cycle t+1.
- A grant to a VC not requesting, or a non-one-hot grant, is ignored: no pop, flit_valid_o=0.
- A packet's trailing flits may arrive before or during VA; they are buffered.
- rst asserted mid-packet: immediate return to reset state, buffered flits discarded.

Optional Feature:
- Macro INPUT_PORT_OVERFLOW_FLAG_EN.
- Defined: overflow_o exists; it is set to 1 on any dropped push and held until rst.
- Undefined: the port and its logic are absent; dropped pushes are silent.

Test Plan:
- ROUTER=(1,1). HEADTAIL to VC0 with dest (3,1) -> out_port_o[0]=EAST, vc_request_o=01 one cycle after the write. Then vc_valid_i=01, vc_new=1, grant=01 -> flit_o vc field=1, credit_o=01, VC0 back to IDLE.
- Destinations (0,1),(1,0),(1,3),(1,1) -> WEST, NORTH, SOUTH, LOCAL.
- Write 8 flits to VC1 with no grants, then a 9th -> 9th dropped. Flag build: overflow_o=1 until rst. Then push+pop in the same cycle on the full FIFO -> both accepted, occupancy stays 8.
- Packet HEAD,BODY,BODY,TAIL on VC0 while VC1 carries a HEADTAIL. Alternating grants -> both streams in order, VC0 stays ACTIVE until TAIL is popped, vc_request_o never re-asserted mid-packet.
- vc_valid_i pulsed while in IDLE/ACTIVE -> no state change. Grant=11 -> no pop.
- rst asserted during VA with 3 flits buffered -> all outputs 0, FIFOs empty. A new HEAD after release is routed normally.
